// File: rtl/shift_pkg.sv
// Shared constants for the shift issue unit: FIFO sizing and the
// bit layout of a queued command {din, shamt, lr, al}.
package shift_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;
    localparam int LVL_W      = 3;

    localparam int CMD_W      = 13;
    localparam int DIN_LSB    = 5;
    localparam int SHAMT_LSB  = 2;
    localparam int LR_BIT     = 1;
    localparam int AL_BIT     = 0;

endpackage

// File: rtl/barrel_shifter8.sv
// 8-bit log barrel shifter: lr=1 shifts left with zero fill,
// lr=0 shifts right filling with din[7] when al=1.
module barrel_shifter8 (
    input  logic [7:0] din_i,
    input  logic [2:0] shamt_i,
    input  logic       lr_i,
    input  logic       al_i,
    output logic [7:0] dout_o
);

    logic       fill;
    logic [7:0] s1;
    logic [7:0] s2;

    assign fill = al_i & din_i[7] & ~lr_i;

    assign s1 = !shamt_i[0] ? din_i :
                lr_i ? {din_i[6:0], 1'b0} :
                       {fill, din_i[7:1]};

    assign s2 = !shamt_i[1] ? s1 :
                lr_i ? {s1[5:0], 2'b00} :
                       {{2{fill}}, s1[7:2]};

    assign dout_o = !shamt_i[2] ? s2 :
                    lr_i ? {s2[3:0], 4'h0} :
                           {{4{fill}}, s2[7:4]};

endmodule

// File: rtl/shift_cmd_fifo.sv
// Command FIFO with wrapping 2-bit pointers and an explicit
// occupancy counter so full and empty are unambiguous.
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [CMD_W-1:0] wdata_i,
    output logic [CMD_W-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // Guard here too so a caller can never corrupt the pointers.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/shift_issue_unit.sv
// Queues shift commands, issues the FIFO head through the barrel
// shifter into a single valid/ready output register.
module shift_issue_unit
    import shift_pkg::*;
#(
    parameter int FIFO_DEPTH = shift_pkg::FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_din,
    input  logic [2:0] in_shamt,
    input  logic       in_lr,
    input  logic       in_al,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_dout,
    output logic [2:0] level
);

    logic             rdy_q;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [7:0]       out_dout_q;
    logic [7:0]       out_dout_d;
    logic             push;
    logic             issue;
    logic             full;
    logic             empty;
    logic [CMD_W-1:0] wcmd;
    logic [CMD_W-1:0] head;
    logic [7:0]       shifted;

    // Held low through reset and for the edge that releases it.
    assign in_ready = rdy_q & ~full;
    assign push     = in_valid & in_ready;
    assign issue    = ~empty & (~out_valid_q | out_ready);
    assign wcmd     = {in_din, in_shamt, in_lr, in_al};

    shift_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (issue),
        .wdata_i (wcmd),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    barrel_shifter8 u_shift (
        .din_i   (head[DIN_LSB +: 8]),
        .shamt_i (head[SHAMT_LSB +: 3]),
        .lr_i    (head[LR_BIT]),
        .al_i    (head[AL_BIT]),
        .dout_o  (shifted)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_dout_d  = out_dout_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_dout_d  = shifted;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_dout_q  <= 8'h00;
        end else begin
            rdy_q       <= 1'b1;
            out_valid_q <= out_valid_d;
            out_dout_q  <= out_dout_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_dout  = out_dout_q;

endmodule

// File: tb/tb_shift_issue_unit.sv
// Directed and random checks of shift_issue_unit against a
// queue-based reference model.
module tb_shift_issue_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_din = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic       in_lr = 1'b0;
    logic       in_al = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_dout;
    logic [2:0] level;

    int n_chk = 0;
    int n_pass = 0;

    bit [7:0] mq[$];
    bit       m_ov;
    bit [7:0] m_od;
    bit       m_rdy;

    always #5 clk = ~clk;

    shift_issue_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din    (in_din),
        .in_shamt  (in_shamt),
        .in_lr     (in_lr),
        .in_al     (in_al),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dout  (out_dout),
        .level     (level)
    );

    function automatic bit [7:0] ref_shift(
        bit [7:0] d, int sh, bit lr, bit al
    );
        int v;
        if (lr) begin
            v = (int'(d) * (1 << sh)) % 256;
        end else begin
            v = int'(d) / (1 << sh);
            if (al && d[7]) v += 256 - (256 >> sh);
        end
        return v[7:0];
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov  = 1'b0;
        m_od  = 8'h00;
        m_rdy = 1'b0;
    endtask

    // One clock: drive at negedge, predict, check at next negedge.
    task automatic step(
        bit iv, bit [7:0] d, bit [2:0] sh, bit lr, bit al, bit ordy
    );
        bit do_issue;
        bit do_push;
        bit [7:0] r;
        in_valid  = iv;
        in_din    = d;
        in_shamt  = sh;
        in_lr     = lr;
        in_al     = al;
        out_ready = ordy;
        #1;
        chk("in_ready", {7'd0, in_ready},
            {7'd0, m_rdy && mq.size() < 4});
        do_issue = mq.size() > 0 && (!m_ov || ordy);
        do_push  = iv && m_rdy && mq.size() < 4;
        if (do_issue) begin
            m_od = mq.pop_front();
            m_ov = 1'b1;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        if (do_push) begin
            r = ref_shift(d, int'(sh), lr, al);
            mq.push_back(r);
        end
        m_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("out_valid", {7'd0, out_valid}, {7'd0, m_ov});
        chk("out_dout", out_dout, m_od);
        chk("level", {5'd0, level}, 8'(mq.size()));
    endtask

    task automatic idle(bit ordy);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_out_dout", out_dout, 8'h00);
        chk("rst_level", {5'd0, level}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h00);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {7'd0, in_ready}, 8'h00);
        idle(1'b1);

        // Directed shifts of 8'h96, result after the second edge.
        step(1'b1, 8'h96, 3'd3, 1'b0, 1'b1, 1'b1);
        chk("lat_n", {7'd0, out_valid}, 8'h00);
        idle(1'b1);
        chk("asr3", out_dout, 8'hF2);
        step(1'b1, 8'h96, 3'd3, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        chk("lsr3", out_dout, 8'h12);
        step(1'b1, 8'h96, 3'd3, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("lsl3", out_dout, 8'hB0);
        step(1'b1, 8'h96, 3'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("sh0", out_dout, 8'h96);
        idle(1'b1);

        // Back-pressure: fill the FIFO, hold the first result.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 1'b0);
        end
        chk("full_in_ready", {7'd0, in_ready}, 8'h00);
        chk("full_level", {5'd0, level}, 8'h04);
        for (int i = 0; i < 7; i++) idle(1'b1);
        chk("drain_level", {5'd0, level}, 8'h00);
        chk("drain_valid", {7'd0, out_valid}, 8'h00);

        // Streaming: one result per cycle, pointers wrap.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 1'b1);
            n_chk++;
            assert (level <= 3'd1) n_pass++;
            else $error("FAIL stream_level observed=%0d expected<=1",
                        level);
        end
        idle(1'b1);
        idle(1'b1);

        // Random mix of traffic and back-pressure.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 3'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Reset with level=3 and a pending result.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 1'b0);
        end
        chk("pre_rst_level", {5'd0, level}, 8'h03);
        chk("pre_rst_valid", {7'd0, out_valid}, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_dout", out_dout, 8'h00);
        chk("mid_rst_level", {5'd0, level}, 8'h00);
        chk("mid_rst_in_ready", {7'd0, in_ready}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'h55, 3'd1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hC3, 3'd2, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        chk("post_rst_res", out_dout, 8'hF0);
        idle(1'b1);
        chk("post_rst_empty", {7'd0, out_valid}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
